// File: rtl/vita49_trig_logic.sv
// -----------------------------------------------------------------------------
// vita49_trig_logic
// Timestamp-triggered sample gate for a VITA-49 style receive path. Software
// arms the block with a start time (integer seconds + 64-bit fractional count)
// and a burst length. Once the live timestamp reaches the programmed start, or
// immediately when requested, samples are passed through for samp_cnt beats.
// A samp_cnt of 0 means the burst runs until software aborts it.
//
// Ports
//   samp_clk              sample clock, the only clock
//   ARESET                asynchronous active-high reset
//   ctrl[2:0]             {immediate, abort, arm}; upper bits unused
//   trig_tsi              programmed start integer seconds
//   trig_tsf_hi/_lo       programmed start fractional count {hi,lo}
//   samp_cnt              samples per burst, 0 = unbounded
//   tsi / tsf             live timestamp from the timing unit
//   in_data / in_valid    incoming sample stream
//   out_data / out_valid  gated sample stream, one cycle behind the input
//   out_sof / out_eof     first / last beat of a burst
//   start_tsi/start_tsf   timestamp that started the current burst
//   status                {27'h0, late, done, run, armed, idle}
// -----------------------------------------------------------------------------
module vita49_trig_logic #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  samp_clk,
    input  logic                  ARESET,
    input  logic [31:0]           ctrl,
    input  logic [31:0]           trig_tsi,
    input  logic [31:0]           trig_tsf_hi,
    input  logic [31:0]           trig_tsf_lo,
    input  logic [31:0]           samp_cnt,
    input  logic [31:0]           tsi,
    input  logic [63:0]           tsf,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [31:0]           start_tsi,
    output logic [63:0]           start_tsf,
    output logic [31:0]           status
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r;

    // Registered processor-side controls
    logic [2:0]  ctrl_r;
    logic [31:0] trig_tsi_r;
    logic [63:0] trig_tsf_r;
    logic [31:0] samp_cnt_r;

    // Values captured at the arm edge
    logic [31:0] cap_tsi_r;
    logic [63:0] cap_tsf_r;
    logic [31:0] cap_cnt_r;

    logic        arm_prev_r;
    logic        first_armed_r;
    logic        passed_r;
    logic        late_r;
    logic [31:0] cnt_r;

    logic        arm_edge_s;
    logic        abort_s;
    logic        imm_s;
    logic        match_s;
    logic [31:0] cnt_next_s;
    logic        unused_ctrl_s;

    assign unused_ctrl_s = ^ctrl[31:3];

    assign arm_edge_s = ctrl_r[0] & ~arm_prev_r;
    assign abort_s    = ctrl_r[1];
    assign imm_s      = ctrl_r[2];
    // Plain unsigned 96-bit compare; a timestamp reload only moves this result.
    assign match_s    = imm_s | ({tsi, tsf} >= {cap_tsi_r, cap_tsf_r});
    assign cnt_next_s = cnt_r + 32'd1;

    assign status = {27'd0, late_r, (state_r == ST_DONE), (state_r == ST_RUN),
                     (state_r == ST_ARMED), (state_r == ST_IDLE)};

    // Register the processor control inputs and the arm-edge history
    always_ff @(posedge samp_clk or posedge ARESET) begin
        if (ARESET) begin
            ctrl_r     <= 3'd0;
            trig_tsi_r <= 32'd0;
            trig_tsf_r <= 64'd0;
            samp_cnt_r <= 32'd0;
            arm_prev_r <= 1'b0;
        end else begin
            ctrl_r     <= ctrl[2:0];
            trig_tsi_r <= trig_tsi;
            trig_tsf_r <= {trig_tsf_hi, trig_tsf_lo};
            samp_cnt_r <= samp_cnt;
            arm_prev_r <= ctrl_r[0];
        end
    end

    // Trigger FSM with the sample gate and all burst outputs
    always_ff @(posedge samp_clk or posedge ARESET) begin
        if (ARESET) begin
            state_r       <= ST_IDLE;
            cap_tsi_r     <= 32'd0;
            cap_tsf_r     <= 64'd0;
            cap_cnt_r     <= 32'd0;
            first_armed_r <= 1'b0;
            passed_r      <= 1'b0;
            late_r        <= 1'b0;
            cnt_r         <= 32'd0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_sof       <= 1'b0;
            out_eof       <= 1'b0;
            start_tsi     <= 32'd0;
            start_tsf     <= 64'd0;
        end else begin
            out_valid     <= 1'b0;
            out_sof       <= 1'b0;
            out_eof       <= 1'b0;
            first_armed_r <= 1'b0;
            if (abort_s) begin
                // A burst cut short still gets a closing eof marker, without data
                if ((state_r == ST_RUN) && passed_r) begin
                    out_eof <= 1'b1;
                end else begin
                    out_eof <= 1'b0;
                end
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (arm_edge_s) begin
                            state_r       <= ST_ARMED;
                            cap_tsi_r     <= trig_tsi_r;
                            cap_tsf_r     <= trig_tsf_r;
                            cap_cnt_r     <= samp_cnt_r;
                            cnt_r         <= 32'd0;
                            passed_r      <= 1'b0;
                            late_r        <= 1'b0;
                            first_armed_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ARMED: begin
                        // The sample present on the match cycle is not passed
                        if (match_s) begin
                            state_r   <= ST_RUN;
                            start_tsi <= tsi;
                            start_tsf <= tsf;
                            if (first_armed_r && !imm_s) begin
                                late_r <= 1'b1;
                            end else begin
                                late_r <= late_r;
                            end
                        end else begin
                            state_r <= ST_ARMED;
                        end
                    end
                    ST_RUN: begin
                        if (in_valid) begin
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_sof   <= ~passed_r;
                            passed_r  <= 1'b1;
                            cnt_r     <= cnt_next_s;
                            // cap_cnt_r of 0 never terminates; the counter just wraps
                            if ((cap_cnt_r != 32'd0) && (cnt_next_s == cap_cnt_r)) begin
                                out_eof <= 1'b1;
                                state_r <= ST_DONE;
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        if (!ctrl_r[0]) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vita49_trig_logic.sv
module tb_vita49_trig_logic;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl;
    logic [31:0] trig_tsi;
    logic [31:0] trig_tsf_hi;
    logic [31:0] trig_tsf_lo;
    logic [31:0] samp_cnt;
    logic [31:0] tsi;
    logic [63:0] tsf;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic [31:0] start_tsi;
    logic [63:0] start_tsf;
    logic [31:0] status;

    int vectors;
    int fails;

    vita49_trig_logic #(.DATA_WIDTH(32)) dut (
        .samp_clk    (clk),
        .ARESET      (rst),
        .ctrl        (ctrl),
        .trig_tsi    (trig_tsi),
        .trig_tsf_hi (trig_tsf_hi),
        .trig_tsf_lo (trig_tsf_lo),
        .samp_cnt    (samp_cnt),
        .tsi         (tsi),
        .tsf         (tsf),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .start_tsi   (start_tsi),
        .start_tsf   (start_tsf),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        ctrl = 32'd0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int beats;
        int eofs;
        int sofs;
        logic [31:0] exp_data;

        vectors = 0;
        fails = 0;
        rst = 1'b1;
        ctrl = 32'd0; trig_tsi = 32'd0; trig_tsf_hi = 32'd0; trig_tsf_lo = 32'd0;
        samp_cnt = 32'd0; tsi = 32'd0; tsf = 64'd0; in_data = 32'd0; in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_status", {32'd0, status}, 64'h1);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_eof", {63'd0, out_eof}, 64'd0);
        check("rst_data", {32'd0, out_data}, 64'd0);
        check("rst_start_tsf", start_tsf, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Timed trigger at (5,100), 4 samples, live tsf counting from (5,0)
        trig_tsi = 32'd5; trig_tsf_hi = 32'd0; trig_tsf_lo = 32'd100; samp_cnt = 32'd4;
        tsi = 32'd5; tsf = 64'd0; in_valid = 1'b1; in_data = 32'd0; ctrl = 32'd1;
        beats = 0;
        exp_data = 32'd101;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (out_valid) begin
                beats++;
                check("t1_data", {32'd0, out_data}, {32'd0, exp_data});
                check("t1_sof", {63'd0, out_sof}, {63'd0, (exp_data == 32'd101)});
                check("t1_eof", {63'd0, out_eof}, {63'd0, (exp_data == 32'd104)});
                exp_data = exp_data + 32'd1;
            end
            tsf = 64'(k);
            in_data = k;
        end
        check("t1_beats", 64'(beats), 64'd4);
        check("t1_status_done", {32'd0, status}, 64'h8);
        check("t1_start_tsi", {32'd0, start_tsi}, 64'd5);
        check("t1_start_tsf", start_tsf, 64'd100);
        in_valid = 1'b0;
        go_idle();
        check("t1_back_idle", {32'd0, status}, 64'h1);

        // Late start: trigger (2,0) already passed by live (7,30)
        trig_tsi = 32'd2; trig_tsf_hi = 32'd0; trig_tsf_lo = 32'd0; samp_cnt = 32'd2;
        tsi = 32'd7; tsf = 64'd30; in_valid = 1'b0; ctrl = 32'd1;
        repeat (2) @(negedge clk);
        check("t2_armed", {32'd0, status}, 64'h02);
        @(negedge clk);
        check("t2_late_run", {32'd0, status}, 64'h14);
        check("t2_start_tsi", {32'd0, start_tsi}, 64'd7);
        check("t2_start_tsf", start_tsf, 64'd30);
        ctrl = 32'd3;
        repeat (2) @(negedge clk);
        check("t2_abort_idle", {32'd0, status}, 64'h11);
        check("t2_abort_no_eof", {63'd0, out_eof}, 64'd0);
        go_idle();

        // Immediate, single-sample burst; the matching-cycle sample is not passed
        samp_cnt = 32'd1; in_valid = 1'b1; in_data = 32'h11; ctrl = 32'd5;
        repeat (2) @(negedge clk);
        check("t3_armed_late_clr", {32'd0, status}, 64'h02);
        in_data = 32'h22;
        @(negedge clk);
        check("t3_run", {32'd0, status}, 64'h04);
        check("t3_no_match_pass", {63'd0, out_valid}, 64'd0);
        in_data = 32'h33;
        @(negedge clk);
        check("t3_valid", {63'd0, out_valid}, 64'd1);
        check("t3_data", {32'd0, out_data}, 64'h33);
        check("t3_sof", {63'd0, out_sof}, 64'd1);
        check("t3_eof", {63'd0, out_eof}, 64'd1);
        check("t3_done", {32'd0, status}, 64'h08);
        @(negedge clk);
        check("t3_one_beat", {63'd0, out_valid}, 64'd0);
        check("t3_data_hold", {32'd0, out_data}, 64'h33);
        go_idle();
        check("t3_idle", {32'd0, status}, 64'h01);

        // Unbounded burst: 1000 samples, then abort
        samp_cnt = 32'd0; in_valid = 1'b0; in_data = 32'd0; ctrl = 32'd5;
        repeat (3) @(negedge clk);
        check("t4_run", {32'd0, status}, 64'h04);
        in_valid = 1'b1;
        beats = 0; eofs = 0; sofs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (out_valid) beats++;
            if (out_eof) eofs++;
            if (out_sof) sofs++;
            in_data = i + 1;
            if (i == 999) in_valid = 1'b0;
        end
        check("t4_beats", 64'(beats), 64'd1000);
        check("t4_no_eof", 64'(eofs), 64'd0);
        check("t4_one_sof", 64'(sofs), 64'd1);
        check("t4_last_data", {32'd0, out_data}, 64'd999);
        ctrl = 32'd7;
        beats = 0; eofs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) beats++;
            if (out_eof) eofs++;
        end
        check("t4_abort_eof", 64'(eofs), 64'd1);
        check("t4_abort_novalid", 64'(beats), 64'd0);
        check("t4_abort_idle", {32'd0, status}, 64'h01);
        go_idle();

        // Gapped input 1010..., three-sample burst
        samp_cnt = 32'd3; in_valid = 1'b0; ctrl = 32'd5;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            in_valid = (j % 2 == 0);
            in_data = 32'h100 + j;
            @(negedge clk);
            check("t5_valid", {63'd0, out_valid}, {63'd0, (j == 0 || j == 2 || j == 4)});
            check("t5_eof", {63'd0, out_eof}, {63'd0, (j == 4)});
            if (j == 2) check("t5_gap_data", {32'd0, out_data}, 64'h102);
        end
        check("t5_done", {32'd0, status}, 64'h08);
        in_valid = 1'b0;
        go_idle();

        // Reset mid-burst, then re-arm
        samp_cnt = 32'd0; in_valid = 1'b1; in_data = 32'h55; ctrl = 32'd5;
        repeat (4) @(negedge clk);
        check("t6_pre_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        check("t6_async_valid", {63'd0, out_valid}, 64'd0);
        check("t6_async_eof", {63'd0, out_eof}, 64'd0);
        check("t6_async_status", {32'd0, status}, 64'h1);
        @(negedge clk);
        rst = 1'b0;
        in_data = 32'h66;
        repeat (3) @(negedge clk);
        check("t6_rearm_run", {32'd0, status}, 64'h04);
        @(negedge clk);
        check("t6_rearm_valid", {63'd0, out_valid}, 64'd1);
        check("t6_rearm_sof", {63'd0, out_sof}, 64'd1);
        check("t6_rearm_data", {32'd0, out_data}, 64'h66);
        ctrl = 32'd2;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
